// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter and fetch/decode pipeline latch.
// Optional redirect event counter enabled by defining FETCH_MISPREDICT_COUNT_EN.
module fetch_pc_unit (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        pred_taken_i,
   input  logic [31:0] pred_target_i,
   input  logic [31:0] imem_data_i,
   output logic [31:0] imem_addr_o,
   output logic [31:0] fd_instruction_o,
   output logic [31:0] fd_pc_o,
   output logic        fd_valid_o
`ifdef FETCH_MISPREDICT_COUNT_EN
   ,
   output logic [31:0] mispredict_count_o
`endif
);

   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_inc;
   logic [31:0] fd_instr_q, fd_instr_d;
   logic [31:0] fd_pc_q, fd_pc_d;
   logic        fd_valid_q, fd_valid_d;
   logic        take_pred;

   assign pc_inc    = pc_q + 32'd1;
   // A prediction only counts when it belongs to a real instruction in F/D.
   assign take_pred = pred_taken_i & fd_valid_q;

   always_comb begin
      pc_d       = pc_inc;
      fd_instr_d = imem_data_i;
      fd_pc_d    = pc_inc;
      fd_valid_d = 1'b1;
      if (redirect_i) begin
         pc_d       = redirect_pc_i;
         fd_instr_d = 32'd0;
         fd_pc_d    = 32'd0;
         fd_valid_d = 1'b0;
      end else if (stall_i) begin
         pc_d       = pc_q;
         fd_instr_d = fd_instr_q;
         fd_pc_d    = fd_pc_q;
         fd_valid_d = fd_valid_q;
      end else if (take_pred) begin
         pc_d       = pred_target_i;
         fd_instr_d = 32'd0;
         fd_pc_d    = 32'd0;
         fd_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         pc_q       <= 32'd0;
         fd_instr_q <= 32'd0;
         fd_pc_q    <= 32'd0;
         fd_valid_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         fd_instr_q <= fd_instr_d;
         fd_pc_q    <= fd_pc_d;
         fd_valid_q <= fd_valid_d;
      end
   end

   assign imem_addr_o      = pc_q;
   assign fd_instruction_o = fd_instr_q;
   assign fd_pc_o          = fd_pc_q;
   assign fd_valid_o       = fd_valid_q;

`ifdef FETCH_MISPREDICT_COUNT_EN
   logic [31:0] cnt_q, cnt_d;

   // Counts every redirect regardless of stall; wraps silently.
   assign cnt_d = redirect_i ? cnt_q + 32'd1 : cnt_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= 32'd0;
      else       cnt_q <= cnt_d;
   end

   assign mispredict_count_o = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus randomized
// traffic compared every cycle against an event-level reference model.
module tb_fetch_pc_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall, redirect, pred_taken;
   logic [31:0] redirect_pc, pred_target;
   logic [31:0] imem_data, imem_addr, fd_instr, fd_pc;
   logic        fd_valid;
   logic [31:0] mis_cnt;
   logic        a0_mode;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a, input logic m);
      if (m) return 32'hA0 + a;
      return {a[15:0] ^ 16'hC3A5, a[31:16] + 16'h1234};
   endfunction

   assign imem_data = mem(imem_addr, a0_mode);

   fetch_pc_unit dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .stall_i         (stall),
      .redirect_i      (redirect),
      .redirect_pc_i   (redirect_pc),
      .pred_taken_i    (pred_taken),
      .pred_target_i   (pred_target),
      .imem_data_i     (imem_data),
      .imem_addr_o     (imem_addr),
      .fd_instruction_o(fd_instr),
      .fd_pc_o         (fd_pc),
      .fd_valid_o      (fd_valid)
`ifdef FETCH_MISPREDICT_COUNT_EN
      ,
      .mispredict_count_o(mis_cnt)
`endif
   );

`ifndef FETCH_MISPREDICT_COUNT_EN
   assign mis_cnt = 32'd0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: classify the cycle as one event, then apply its effect.
   typedef enum {EV_REDIRECT, EV_HOLD, EV_TAKEN, EV_ADVANCE} ev_t;
   logic [31:0] m_pc, m_instr, m_fpc, m_cnt;
   logic        m_valid;

   always @(posedge clk or posedge rst) begin
      ev_t ev;
      if (rst) begin
         m_pc = 0; m_instr = 0; m_fpc = 0; m_valid = 0; m_cnt = 0;
      end else begin
         if (redirect)                   ev = EV_REDIRECT;
         else if (stall)                 ev = EV_HOLD;
         else if (pred_taken && m_valid) ev = EV_TAKEN;
         else                            ev = EV_ADVANCE;
         if (redirect) m_cnt = m_cnt + 1;
         case (ev)
            EV_REDIRECT: begin m_pc = redirect_pc; m_instr = 0; m_fpc = 0; m_valid = 0; end
            EV_TAKEN:    begin m_pc = pred_target; m_instr = 0; m_fpc = 0; m_valid = 0; end
            EV_ADVANCE:  begin
               m_instr = mem(m_pc, a0_mode);
               m_fpc   = m_pc + 1;
               m_valid = 1;
               m_pc    = m_pc + 1;
            end
            default: ;
         endcase
      end
   end

   always @(negedge clk) begin
      chk("model_imem_addr", imem_addr, m_pc);
      chk("model_fd_instr", fd_instr, m_instr);
      chk("model_fd_pc", fd_pc, m_fpc);
      chk("model_fd_valid", {31'd0, fd_valid}, {31'd0, m_valid});
`ifdef FETCH_MISPREDICT_COUNT_EN
      chk("model_mis_cnt", mis_cnt, m_cnt);
`endif
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      stall = 0; redirect = 0; pred_taken = 0;
      redirect_pc = 0; pred_target = 0;
   endtask

   initial begin
      a0_mode = 1;
      idle_inputs();
      rst = 0;
      #1 rst = 1;
      #2;
      chk("reset_imem_addr", imem_addr, 32'd0);
      chk("reset_fd_valid", {31'd0, fd_valid}, 32'd0);
      chk("reset_fd_pc", fd_pc, 32'd0);
      chk("reset_mis_cnt", mis_cnt, 32'd0);
      #4 rst = 0;
      chk("pre_edge_fd_valid", {31'd0, fd_valid}, 32'd0);

      for (int i = 1; i <= 3; i++) begin
         step();
         chk("idle_imem_addr", imem_addr, i);
         chk("idle_fd_pc", fd_pc, i);
         chk("idle_fd_instr", fd_instr, 32'hA0 + i - 1);
         chk("idle_fd_valid", {31'd0, fd_valid}, 32'd1);
      end
      step(); step();
      chk("at5_imem_addr", imem_addr, 32'd5);

      stall = 1;
      step(); step();
      chk("stall_imem_addr", imem_addr, 32'd5);
      chk("stall_fd_instr", fd_instr, 32'hA4);
      chk("stall_fd_pc", fd_pc, 32'd5);
      chk("stall_fd_valid", {31'd0, fd_valid}, 32'd1);
      stall = 0;
      step();
      chk("resume_imem_addr", imem_addr, 32'd6);
      step(); step();
      chk("at8_imem_addr", imem_addr, 32'd8);

      pred_taken = 1; pred_target = 32'h40;
      step();
      chk("taken_imem_addr", imem_addr, 32'h40);
      chk("taken_fd_valid", {31'd0, fd_valid}, 32'd0);
      chk("taken_fd_instr", fd_instr, 32'd0);
      pred_taken = 1;
      step();
      chk("after_taken_fd_pc", fd_pc, 32'h41);
      chk("after_taken_fd_valid", {31'd0, fd_valid}, 32'd1);
      chk("ignored_pred_imem_addr", imem_addr, 32'h41);
      pred_taken = 0;

      redirect = 1; redirect_pc = 32'h100; stall = 1; pred_taken = 1; pred_target = 32'h80;
      step();
      idle_inputs();
      chk("redir_imem_addr", imem_addr, 32'h100);
      chk("redir_fd_valid", {31'd0, fd_valid}, 32'd0);
`ifdef FETCH_MISPREDICT_COUNT_EN
      chk("redir_mis_cnt", mis_cnt, 32'd1);
`endif

      redirect = 1; redirect_pc = 32'h37;
      step();
      idle_inputs();
      chk("at37_imem_addr", imem_addr, 32'h37);
      stall = 1; redirect = 1; redirect_pc = 32'h55;
      #2 rst = 1;
      #1;
      chk("async_rst_imem_addr", imem_addr, 32'd0);
      chk("async_rst_fd_instr", fd_instr, 32'd0);
      chk("async_rst_fd_valid", {31'd0, fd_valid}, 32'd0);
      chk("async_rst_mis_cnt", mis_cnt, 32'd0);
      idle_inputs();
      #1 rst = 0;
      step();
      chk("post_rst_imem_addr", imem_addr, 32'd1);
      chk("post_rst_fd_pc", fd_pc, 32'd1);

      redirect = 1; redirect_pc = 32'hFFFF_FFFF;
      step();
      idle_inputs();
      step();
      chk("wrap_imem_addr", imem_addr, 32'd0);
      chk("wrap_fd_pc", fd_pc, 32'd0);
      chk("wrap_fd_instr", fd_instr, 32'h9F);

      a0_mode = 0;
      for (int i = 0; i < 3000; i++) begin
         stall       = ($urandom_range(0, 3) == 0);
         redirect    = ($urandom_range(0, 7) == 0);
         pred_taken  = ($urandom_range(0, 2) == 0);
         redirect_pc = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom;
         pred_target = $urandom;
         if ($urandom_range(0, 199) == 0) begin
            #1 rst = 1;
            #1 rst = 0;
         end
         step();
      end
      idle_inputs();
      step();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/fetch_pc_unit.md
FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 clock  input  1  rising-edge system clock.
REQ-002 reset  input  1  asynchronous, active-high; one clock domain only.
REQ-003 stall  input  1  hazard hold; freezes PC and F/D latch.
REQ-004 redirect  input  1  execute-stage mispredict/resolution redirect.
REQ-005 redirectPc  input  32  corrected fetch target, valid when redirect=1.
REQ-006 predTaken  input  1  decode-stage branch/jump taken prediction for the F/D instruction.
REQ-007 predTarget  input  32  decode-stage computed target, valid when predTaken=1.
REQ-008 imemData  input  32  instruction word at imemAddr, combinational read, same cycle.
REQ-009 imemAddr  output  32  current PC, word address.
REQ-010 fdInstruction  output  32  latched instruction for the decode stage.
REQ-011 fdPc  output  32  latched PC+1 of fdInstruction.
REQ-012 fdValid  output  1  fdInstruction is a real instruction, not a bubble.
REQ-013 mispredictCount  output  32  redirect event count; present only per REQ-027.

Function
REQ-014 PC register SHALL drive imemAddr directly; no extra output latency.
REQ-015 Next-PC priority, highest first: redirect -> redirectPc; stall -> hold PC; predTaken and fdValid -> predTarget; else PC+1.
REQ-016 PC+1 SHALL be 32-bit unsigned, wrapping 0xFFFFFFFF -> 0x00000000, no overflow flag.
REQ-017 Normal advance: F/D latch loads fdInstruction=imemData, fdPc=PC+1, fdValid=1.
REQ-018 redirect=1: F/D latch loads bubble: fdInstruction=0, fdPc=0, fdValid=0; redirect overrides stall and predTaken in the same cycle.
REQ-019 predTaken=1 with fdValid=1 and stall=0: F/D latch loads bubble; one-cycle taken penalty.
REQ-020 predTaken with fdValid=0 SHALL be ignored.
REQ-021 stall=1 without redirect: PC, fdInstruction, fdPc and fdValid hold; predTaken deferred until stall drops.
REQ-022 Bubble encoding SHALL be all-zero instruction (nop).
REQ-023 Outputs SHALL change only on the rising clock edge or on reset assertion.

Reset
REQ-024 reset=1 SHALL immediately, without a clock edge, force PC=0, imemAddr=0, fdInstruction=0, fdPc=0, fdValid=0, mispredictCount=0.
REQ-025 Reset asserted mid-operation SHALL discard any in-flight redirect, stall or prediction; nothing is replayed after release.
REQ-026 First rising edge after release with no stall SHALL fetch address 0: fdPc=1, imemAddr=1.

Configuration
REQ-027 Macro FETCH_MISPREDICT_COUNT_EN defined: mispredictCount port exists; increments by 1 on each edge where redirect=1 and reset=0; wraps 0xFFFFFFFF -> 0; unaffected by stall.
REQ-028 Macro undefined: port and counter logic absent; all other behaviour identical.

Verification
REQ-029 Reset, release, 3 idle edges, imemData=0xA0+addr -> imemAddr 1,2,3; fdPc 1,2,3; fdInstruction 0xA0,0xA1,0xA2; fdValid 0 before first edge, 1 after.
REQ-030 stall=1 for 2 edges at PC=5 -> imemAddr stays 5; fdInstruction, fdPc, fdValid unchanged; resumes at 6 on first edge after stall=0.
REQ-031 fdValid=1 at PC=8, predTaken=1, predTarget=0x40 -> next imemAddr=0x40, fdValid=0, fdInstruction=0; following edge fdPc=0x41, fdValid=1.
REQ-032 redirect=1, redirectPc=0x100, stall=1, predTaken=1 in the same cycle -> imemAddr=0x100, fdValid=0; with macro defined, mispredictCount increments from 0 to 1.
REQ-033 reset asserted asynchronously between edges at PC=0x37 -> all outputs 0 before next edge; PC=0xFFFFFFFF advance -> imemAddr=0.
